// File: rtl/csr_ctrl.sv
// Machine-mode CSR controller: CSR instruction sequencing, trap/MRET entry and
// the 64-bit cycle/instret counters. The op-type package and the CSR
// read-modify-write ALU share this file so the block is self-contained.

package csr_pkg;
    // 2'b00 is deliberately left unused so it decodes as an illegal op.
    typedef enum logic [1:0] {
        CSR_RW = 2'b01,
        CSR_RS = 2'b10,
        CSR_RC = 2'b11
    } csr_op_e;
endpackage

// Read-modify-write datapath for CSR instructions.
module csr_alu
    import csr_pkg::*;
(
    input  csr_op_e     op,
    input  logic [31:0] csr_data,
    input  logic [31:0] data,
    output logic [31:0] result
);
    // New CSR value from the old value and the operand.
    always_comb begin
        case (op)
            CSR_RW:  result = data;
            CSR_RS:  result = csr_data | data;
            CSR_RC:  result = csr_data & ~data;
            default: result = csr_data;
        endcase
    end
endmodule

module csr_ctrl
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_req,
    input  logic [11:0] csr_addr,
    input  csr_op_e     csr_op,
    input  logic [31:0] csr_wdata,
    input  logic        csr_wr_suppress,
    input  logic        trap_req,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic        mret_req,
    input  logic        instret_inc,
    output logic        busy,
    output logic        csr_ack,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    output logic        trap_ack,
    output logic [31:0] redirect_pc
);
    typedef enum logic [1:0] {StIdle, StRead, StWrite, StTrap} state_e;

    state_e      state_q;
    logic [11:0] addr_q;
    csr_op_e     op_q;
    logic [31:0] wdata_q;
    logic [31:0] old_q;
    logic        wr_en_q;
    logic        illegal_q;

    logic        mie_q;
    logic        mpie_q;
    logic [31:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [63:0] mcycle_q;
    logic [63:0] minstret_q;

    logic [31:0] rd_val;
    logic        rd_hit;
    logic        op_valid;
    logic        wr_en;
    logic        illegal;
    logic [31:0] alu_result;
    logic        commit;
    logic        wr_mcycle_lo;
    logic        wr_mcycle_hi;
    logic        wr_minstret_lo;
    logic        wr_minstret_hi;
    logic [32:0] mcycle_lo_inc;
    logic [32:0] minstret_lo_inc;
    logic [63:0] mcycle_d;
    logic [63:0] minstret_d;

    assign busy = (state_q != StIdle);

    // CSR read mux on the live request address; unimplemented addresses miss.
    always_comb begin
        rd_val = '0;
        rd_hit = 1'b1;
        case (csr_addr)
            12'h300:          rd_val = {24'b0, mpie_q, 3'b0, mie_q, 3'b0};
            12'h305:          rd_val = mtvec_q;
            12'h340:          rd_val = mscratch_q;
            12'h341:          rd_val = mepc_q;
            12'h342:          rd_val = mcause_q;
            12'hB00, 12'hC00: rd_val = mcycle_q[31:0];
            12'hB80, 12'hC80: rd_val = mcycle_q[63:32];
            12'hB02, 12'hC02: rd_val = minstret_q[31:0];
            12'hB82, 12'hC82: rd_val = minstret_q[63:32];
            default:          rd_hit = 1'b0;
        endcase
    end

    // Legality of the request; RW always writes, RS/RC only when not suppressed.
    always_comb begin
        op_valid = (csr_op == CSR_RW) || (csr_op == CSR_RS) || (csr_op == CSR_RC);
        wr_en    = (csr_op == CSR_RW) || !csr_wr_suppress;
        illegal  = !rd_hit || !op_valid || (wr_en && (csr_addr[11:10] == 2'b11));
    end

    csr_alu u_csr_alu (
        .op       (op_q),
        .csr_data (old_q),
        .data     (wdata_q),
        .result   (alu_result)
    );

    // Commit strobes, asserted on the READ->WRITE edge.
    always_comb begin
        commit         = (state_q == StRead) && !illegal_q && wr_en_q;
        wr_mcycle_lo   = commit && (addr_q == 12'hB00);
        wr_mcycle_hi   = commit && (addr_q == 12'hB80);
        wr_minstret_lo = commit && (addr_q == 12'hB02);
        wr_minstret_hi = commit && (addr_q == 12'hB82);
    end

    // Counter next state; a write to the low half also kills the carry.
    always_comb begin
        mcycle_lo_inc   = {1'b0, mcycle_q[31:0]} + 33'd1;
        minstret_lo_inc = {1'b0, minstret_q[31:0]} + {32'b0, instret_inc};
        mcycle_d[31:0]    = wr_mcycle_lo ? alu_result : mcycle_lo_inc[31:0];
        mcycle_d[63:32]   = wr_mcycle_hi ? alu_result :
                            mcycle_q[63:32] + {31'b0, mcycle_lo_inc[32] & ~wr_mcycle_lo};
        minstret_d[31:0]  = wr_minstret_lo ? alu_result : minstret_lo_inc[31:0];
        minstret_d[63:32] = wr_minstret_hi ? alu_result :
                            minstret_q[63:32] +
                            {31'b0, minstret_lo_inc[32] & ~wr_minstret_lo};
    end

    // Counters: held at zero in reset, count from the first released edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    // Control FSM with registered acks, read data and redirect target.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            op_q        <= CSR_RW;
            wdata_q     <= '0;
            old_q       <= '0;
            wr_en_q     <= 1'b0;
            illegal_q   <= 1'b0;
            mie_q       <= 1'b0;
            mpie_q      <= 1'b0;
            mtvec_q     <= '0;
            mscratch_q  <= '0;
            mepc_q      <= '0;
            mcause_q    <= '0;
            csr_ack     <= 1'b0;
            csr_rdata   <= '0;
            csr_illegal <= 1'b0;
            trap_ack    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            csr_ack  <= 1'b0;
            trap_ack <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (trap_req) begin
                        mepc_q      <= {trap_pc[31:2], 2'b00};
                        mcause_q    <= trap_cause;
                        mpie_q      <= mie_q;
                        mie_q       <= 1'b0;
                        trap_ack    <= 1'b1;
                        redirect_pc <= mtvec_q;
                        state_q     <= StTrap;
                    end else if (mret_req) begin
                        mie_q       <= mpie_q;
                        mpie_q      <= 1'b1;
                        trap_ack    <= 1'b1;
                        redirect_pc <= mepc_q;
                        state_q     <= StTrap;
                    end else if (csr_req) begin
                        addr_q    <= csr_addr;
                        op_q      <= csr_op;
                        wdata_q   <= csr_wdata;
                        old_q     <= rd_val;
                        wr_en_q   <= wr_en;
                        illegal_q <= illegal;
                        state_q   <= StRead;
                    end
                end
                StRead: begin
                    csr_ack     <= 1'b1;
                    csr_illegal <= illegal_q;
                    csr_rdata   <= illegal_q ? 32'h0 : old_q;
                    if (commit) begin
                        case (addr_q)
                            12'h300: begin
                                mie_q  <= alu_result[3];
                                mpie_q <= alu_result[7];
                            end
                            12'h305: mtvec_q    <= {alu_result[31:2], 2'b00};
                            12'h340: mscratch_q <= alu_result;
                            12'h341: mepc_q     <= {alu_result[31:2], 2'b00};
                            12'h342: mcause_q   <= alu_result;
                            default: ;
                        endcase
                    end
                    state_q <= StWrite;
                end
                StWrite: state_q <= StIdle;
                StTrap:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_csr_ctrl.sv
// Directed self-checking bench for csr_ctrl.
module tb_csr_ctrl;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_req;
    logic [11:0] csr_addr;
    csr_op_e     csr_op;
    logic [31:0] csr_wdata;
    logic        csr_wr_suppress;
    logic        trap_req;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic        mret_req;
    logic        instret_inc;
    logic        busy;
    logic        csr_ack;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_ack;
    logic [31:0] redirect_pc;

    int tests = 0;
    int fails = 0;

    csr_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .csr_req         (csr_req),
        .csr_addr        (csr_addr),
        .csr_op          (csr_op),
        .csr_wdata       (csr_wdata),
        .csr_wr_suppress (csr_wr_suppress),
        .trap_req        (trap_req),
        .trap_pc         (trap_pc),
        .trap_cause      (trap_cause),
        .mret_req        (mret_req),
        .instret_inc     (instret_inc),
        .busy            (busy),
        .csr_ack         (csr_ack),
        .csr_rdata       (csr_rdata),
        .csr_illegal     (csr_illegal),
        .trap_ack        (trap_ack),
        .redirect_pc     (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CSR instruction; lat counts edges from request to visible csr_ack.
    // Returns once the FSM is back in IDLE.
    task automatic do_csr(input logic [11:0] a, input csr_op_e op, input logic [31:0] d,
                          input logic sup, output logic [31:0] rdata, output logic ill,
                          output int lat);
        csr_addr = a;
        csr_op = op;
        csr_wdata = d;
        csr_wr_suppress = sup;
        csr_req = 1'b1;
        lat = 0;
        rdata = 'x;
        ill = 1'bx;
        for (int i = 0; i < 10; i++) begin
            tick();
            lat++;
            if (csr_ack) begin
                rdata = csr_rdata;
                ill = csr_illegal;
                break;
            end
        end
        csr_req = 1'b0;
        if (!(ill === 1'b0 || ill === 1'b1)) begin
            tests++;
            fails++;
            $display("FAIL csr_timeout addr=%h: no csr_ack within 10 cycles", a);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        tests++;
        if ({busy, csr_ack, trap_ack, csr_illegal} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags: got %b want 0000", {busy, csr_ack, trap_ack, csr_illegal});
        end
        tests++;
        if (csr_rdata !== 32'h0 || redirect_pc !== 32'h0) begin
            fails++;
            $display("FAIL reset_data: got rdata=%h pc=%h want 0/0", csr_rdata, redirect_pc);
        end
        rst = 1'b0;
    endtask

    task automatic test_rs_set();
        logic [31:0] r;
        logic        il;
        int          lat;
        do_csr(12'h340, CSR_RW, 32'hF0, 1'b0, r, il, lat);
        tests++;
        if (r !== 32'h0) begin
            fails++;
            $display("FAIL mscratch_reset: got %h want 00000000", r);
        end
        do_csr(12'h340, CSR_RS, 32'h0F, 1'b0, r, il, lat);
        tests++;
        if (lat !== 2) begin
            fails++;
            $display("FAIL ack_latency: got %0d want 2", lat);
        end
        tests++;
        if (r !== 32'hF0 || il !== 1'b0) begin
            fails++;
            $display("FAIL rs_old: got %h ill=%b want 000000f0 ill=0", r, il);
        end
        do_csr(12'h340, CSR_RS, 32'h0, 1'b1, r, il, lat);
        tests++;
        if (r !== 32'hFF) begin
            fails++;
            $display("FAIL rs_readback: got %h want 000000ff", r);
        end
    endtask

    task automatic test_rc_suppress();
        logic [31:0] r;
        logic        il;
        int          lat;
        do_csr(12'h340, CSR_RC, 32'hFF, 1'b1, r, il, lat);
        tests++;
        if (r !== 32'hFF) begin
            fails++;
            $display("FAIL rc_sup_old: got %h want 000000ff", r);
        end
        do_csr(12'h340, CSR_RS, 32'h0, 1'b1, r, il, lat);
        tests++;
        if (r !== 32'hFF) begin
            fails++;
            $display("FAIL rc_sup_unchanged: got %h want 000000ff", r);
        end
    endtask

    task automatic test_trap();
        logic [31:0] r;
        logic [31:0] rpc;
        logic        il;
        int          lat;
        logic        got_trap;
        logic        got_csr;
        logic        both;
        logic        order_ok;
        // Low bits of mtvec read back as zero.
        do_csr(12'h305, CSR_RW, 32'h103, 1'b0, r, il, lat);
        do_csr(12'h305, CSR_RS, 32'h0, 1'b1, r, il, lat);
        tests++;
        if (r !== 32'h100) begin
            fails++;
            $display("FAIL mtvec_mask: got %h want 00000100", r);
        end
        do_csr(12'h300, CSR_RW, 32'h8, 1'b0, r, il, lat);
        trap_pc = 32'h203;
        trap_cause = 32'hB;
        trap_req = 1'b1;
        csr_addr = 12'h341;
        csr_op = CSR_RS;
        csr_wdata = 32'h0;
        csr_wr_suppress = 1'b1;
        csr_req = 1'b1;
        got_trap = 1'b0;
        got_csr = 1'b0;
        both = 1'b0;
        order_ok = 1'b1;
        rpc = 'x;
        r = 'x;
        for (int i = 0; i < 20 && !got_csr; i++) begin
            tick();
            if (trap_ack && csr_ack) both = 1'b1;
            if (trap_ack) begin
                got_trap = 1'b1;
                rpc = redirect_pc;
                trap_req = 1'b0;
            end
            if (csr_ack) begin
                got_csr = 1'b1;
                if (!got_trap) order_ok = 1'b0;
                r = csr_rdata;
                csr_req = 1'b0;
            end
        end
        trap_req = 1'b0;
        csr_req = 1'b0;
        tick();
        tests++;
        if (!(got_trap && got_csr && order_ok && !both)) begin
            fails++;
            $display("FAIL trap_priority: got trap=%b csr=%b order=%b both=%b want 1 1 1 0",
                     got_trap, got_csr, order_ok, both);
        end
        tests++;
        if (rpc !== 32'h100) begin
            fails++;
            $display("FAIL trap_redirect: got %h want 00000100", rpc);
        end
        tests++;
        if (r !== 32'h200) begin
            fails++;
            $display("FAIL trap_mepc: got %h want 00000200", r);
        end
        do_csr(12'h342, CSR_RS, 32'h0, 1'b1, r, il, lat);
        tests++;
        if (r !== 32'hB) begin
            fails++;
            $display("FAIL trap_mcause: got %h want 0000000b", r);
        end
        do_csr(12'h300, CSR_RS, 32'h0, 1'b1, r, il, lat);
        tests++;
        if (r !== 32'h80) begin
            fails++;
            $display("FAIL trap_mstatus: got %h want 00000080", r);
        end
    endtask

    task automatic test_mret();
        logic [31:0] r;
        logic [31:0] rpc;
        logic        il;
        int          lat;
        logic        got;
        mret_req = 1'b1;
        got = 1'b0;
        rpc = 'x;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (trap_ack) begin
                got = 1'b1;
                rpc = redirect_pc;
                mret_req = 1'b0;
            end
        end
        mret_req = 1'b0;
        tick();
        tests++;
        if (!got || rpc !== 32'h200) begin
            fails++;
            $display("FAIL mret_redirect: got ack=%b pc=%h want 1 00000200", got, rpc);
        end
        tests++;
        if (trap_ack !== 1'b0 || redirect_pc !== 32'h200) begin
            fails++;
            $display("FAIL mret_hold: got ack=%b pc=%h want 0 00000200", trap_ack, redirect_pc);
        end
        do_csr(12'h300, CSR_RS, 32'h0, 1'b1, r, il, lat);
        tests++;
        if (r !== 32'h88) begin
            fails++;
            $display("FAIL mret_mstatus: got %h want 00000088", r);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] r;
        logic        il;
        int          lat;
        do_csr(12'hC00, CSR_RW, 32'h1234, 1'b0, r, il, lat);
        tests++;
        if (il !== 1'b1 || r !== 32'h0) begin
            fails++;
            $display("FAIL ill_ro_write: got ill=%b rdata=%h want 1 00000000", il, r);
        end
        do_csr(12'hC00, CSR_RW, 32'h0, 1'b1, r, il, lat);
        tests++;
        if (il !== 1'b1) begin
            fails++;
            $display("FAIL ill_ro_rw_sup: got ill=%b want 1", il);
        end
        do_csr(12'h7C0, CSR_RS, 32'h0, 1'b1, r, il, lat);
        tests++;
        if (il !== 1'b1 || r !== 32'h0) begin
            fails++;
            $display("FAIL ill_unimpl: got ill=%b rdata=%h want 1 00000000", il, r);
        end
        do_csr(12'h340, csr_op_e'(2'b00), 32'h55, 1'b0, r, il, lat);
        tests++;
        if (il !== 1'b1 || r !== 32'h0) begin
            fails++;
            $display("FAIL ill_op: got ill=%b rdata=%h want 1 00000000", il, r);
        end
        do_csr(12'h340, CSR_RS, 32'h0, 1'b1, r, il, lat);
        tests++;
        if (r !== 32'hFF) begin
            fails++;
            $display("FAIL ill_no_change: got %h want 000000ff", r);
        end
        do_csr(12'hC00, CSR_RS, 32'h0, 1'b1, r, il, lat);
        tests++;
        if (il !== 1'b0) begin
            fails++;
            $display("FAIL ro_read_legal: got ill=%b want 0", il);
        end
    endtask

    task automatic test_counters();
        logic [31:0] r;
        logic        il;
        int          lat;
        do_csr(12'hB80, CSR_RW, 32'h0, 1'b0, r, il, lat);
        do_csr(12'hB00, CSR_RW, 32'hFFFF_FFFF, 1'b0, r, il, lat);
        do_csr(12'hB80, CSR_RS, 32'h0, 1'b1, r, il, lat);
        tests++;
        if (r !== 32'h1) begin
            fails++;
            $display("FAIL mcycle_carry: got %h want 00000001", r);
        end
        do_csr(12'hC80, CSR_RS, 32'h0, 1'b1, r, il, lat);
        tests++;
        if (r !== 32'h1 || il !== 1'b0) begin
            fails++;
            $display("FAIL cycleh_alias: got %h ill=%b want 00000001 0", r, il);
        end
        do_csr(12'hB02, CSR_RW, 32'h0, 1'b0, r, il, lat);
        instret_inc = 1'b1;
        repeat (5) tick();
        instret_inc = 1'b0;
        do_csr(12'hC02, CSR_RS, 32'h0, 1'b1, r, il, lat);
        tests++;
        if (r !== 32'h5) begin
            fails++;
            $display("FAIL instret_count: got %h want 00000005", r);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] r;
        logic        il;
        int          lat;
        logic        saw_ack;
        csr_addr = 12'h340;
        csr_op = CSR_RW;
        csr_wdata = 32'hAA;
        csr_wr_suppress = 1'b0;
        csr_req = 1'b1;
        tick();
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_busy: got %b want 1", busy);
        end
        rst = 1'b1;
        csr_req = 1'b0;
        saw_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (csr_ack) saw_ack = 1'b1;
        end
        tests++;
        if (saw_ack !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_state: got ack=%b busy=%b want 0 0", saw_ack, busy);
        end
        rst = 1'b0;
        // First released edge accepts the read and latches the still-zero counter.
        do_csr(12'hB00, CSR_RS, 32'h0, 1'b1, r, il, lat);
        tests++;
        if (r !== 32'h0) begin
            fails++;
            $display("FAIL cnt_after_rst: got %h want 00000000", r);
        end
        do_csr(12'hB00, CSR_RS, 32'h0, 1'b1, r, il, lat);
        tests++;
        if (r !== 32'h3) begin
            fails++;
            $display("FAIL cnt_first_inc: got %h want 00000003", r);
        end
        do_csr(12'h340, CSR_RS, 32'h0, 1'b1, r, il, lat);
        tests++;
        if (r !== 32'h0) begin
            fails++;
            $display("FAIL abort_no_commit: got %h want 00000000", r);
        end
    endtask

    initial begin
        rst = 1'b1;
        csr_req = 1'b0;
        csr_addr = '0;
        csr_op = CSR_RW;
        csr_wdata = '0;
        csr_wr_suppress = 1'b0;
        trap_req = 1'b0;
        trap_pc = '0;
        trap_cause = '0;
        mret_req = 1'b0;
        instret_inc = 1'b0;
        test_reset();
        test_rs_set();
        test_rc_suppress();
        test_trap();
        test_mret();
        test_illegal();
        test_counters();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
